// File: rtl/s_type_store_unit_pkg.sv
// s_type_store_unit_pkg: shared widths, RV32 load/store encodings and store FSM states
package s_type_store_unit_pkg;
  localparam int MSB = 31;
  localparam int LSB = 0;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
endpackage

// File: rtl/s_type_store_unit_align.sv
// store_lane_align: positions store data and byte mask across two adjacent words
module store_lane_align
  import s_type_store_unit_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [MSB:LSB]   rs2data,
  output logic [7:0]       mask8,
  output logic [63:0]      data64,
  output logic             need_beat1
);
  logic [7:0]  size_mask;
  logic [63:0] raw;
  always_comb begin
    size_mask  = funct3 == SB ? 8'h01 : funct3 == SH ? 8'h03 : 8'h0f;
    raw        = funct3 == SB ? {56'b0, rs2data[7:0]} : funct3 == SH ? {48'b0, rs2data[15:0]} : {32'b0, rs2data};
    mask8      = size_mask << off;
    data64     = raw << {off, 3'b000};
    need_beat1 = |mask8[7:4];
  end
endmodule

// File: rtl/s_type_store_unit.sv
// s_type_store_unit: turns SB/SH/SW into aligned strobed write beats, splitting word-crossing stores
module s_type_store_unit
  import s_type_store_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [MSB:LSB]   idata,
  input  logic [MSB:LSB]   daddr,
  input  logic [MSB:LSB]   rs2data,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [MSB:LSB]   mem_addr,
  output logic [MSB:LSB]   mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic             done,
  output logic             err
);
  state_t         state, state_n;
  logic [7:0]     mask8;
  logic [63:0]    data64;
  logic           need_beat1, legal, accept, reject, go, hs, last;
  logic [MSB:LSB] b1_addr, b1_wdata, base;
  logic [3:0]     b1_wstrb;
  logic           unused_bits;
  store_lane_align u_align (
    .funct3    (idata[14:12]),
    .off       (daddr[1:0]),
    .rs2data   (rs2data),
    .mask8     (mask8),
    .data64    (data64),
    .need_beat1(need_beat1)
  );
  assign unused_bits = ^{idata[31:15], idata[11:7]};
  assign req_ready   = state == IDLE;
  assign mem_valid   = state != IDLE;
  assign base        = {daddr[MSB:2], 2'b00};
  always_comb begin
    legal  = idata[6:0] == STORE_OP && (idata[14:12] == SB || idata[14:12] == SH || idata[14:12] == SW);
    accept = req_valid && req_ready;
    reject = accept && (!legal || (need_beat1 && !ALLOW_MISALIGNED));
    go     = accept && !reject;
    hs     = mem_valid && mem_ready;
    // an empty beat1 strobe marks a store that fits in one word
    last   = state == BEAT1 || (state == BEAT0 && b1_wstrb == 4'b0);
    state_n = state == IDLE ? (go ? BEAT0 : IDLE) : !hs ? state : last ? IDLE : BEAT1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      b1_addr   <= '0;
      b1_wdata  <= '0;
      b1_wstrb  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= hs && last;
      err  <= reject;
      if (go) begin
        mem_addr  <= base;
        mem_wdata <= data64[31:0];
        mem_wstrb <= mask8[3:0];
        b1_addr   <= base + 32'd4;
        b1_wdata  <= data64[63:32];
        b1_wstrb  <= mask8[7:4];
      end else if (hs) begin
        mem_addr  <= last ? '0 : b1_addr;
        mem_wdata <= last ? '0 : b1_wdata;
        mem_wstrb <= last ? '0 : b1_wstrb;
      end
    end
  end
endmodule

// File: tb/tb_s_type_store_unit.sv
// tb_s_type_store_unit: random and directed stores checked against a beat-queue reference model
module tb_s_type_store_unit;
  import s_type_store_unit_pkg::*;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} beat_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, mem_ready = 1'b0;
  logic [31:0] idata = '0, daddr = '0, rs2data = '0;
  logic        req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        s_req_valid = 1'b0, s_mem_ready = 1'b1;
  logic [31:0] s_idata = '0, s_daddr = '0, s_rs2data = '0;
  logic        s_req_ready, s_mem_valid, s_done, s_err;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_wstrb;
  beat_t       q[$];
  logic        exp_done = 1'b0, exp_err = 1'b0;
  int          vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  s_type_store_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .idata(idata), .daddr(daddr), .rs2data(rs2data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .done(done), .err(err)
  );
  s_type_store_unit #(.ALLOW_MISALIGNED(1'b0)) u_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .idata(s_idata), .daddr(s_daddr), .rs2data(s_rs2data), .mem_valid(s_mem_valid),
    .mem_ready(s_mem_ready), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_wstrb(s_mem_wstrb), .done(s_done), .err(s_err)
  );
  function automatic logic [31:0] st(input logic [2:0] f3);
    return {17'h0, f3, 5'h0, 7'b0100011};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model();
    int n;
    logic [63:0] mask, data;
    logic [31:0] base;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (q.size() != 0) begin
      if (mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_done = 1'b1;
      end
    end else if (req_valid) begin
      if (idata[6:0] != 7'b0100011 || idata[14:12] > 3'd2) exp_err = 1'b1;
      else begin
        n    = 1 << idata[14:12];
        mask = ((64'd1 << n) - 1) << daddr[1:0];
        data = ({32'b0, rs2data} & ((64'd1 << (8 * n)) - 1)) << (8 * daddr[1:0]);
        base = daddr & ~32'd3;
        q.push_back('{base, data[31:0], mask[3:0]});
        if (mask[7:4] != 0) q.push_back('{base + 32'd4, data[63:32], mask[7:4]});
      end
    end
  endtask
  task automatic compare();
    chk("mem_valid", mem_valid, q.size() != 0);
    chk("req_ready", req_ready, q.size() == 0);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
      chk("mem_wstrb", mem_wstrb, q[0].s);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    compare();
  endtask
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    idata     = st(f3);
    daddr     = a;
    rs2data   = d;
    step();
    req_valid = 1'b0;
  endtask
  task automatic s_send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d);
    s_req_valid = 1'b1;
    s_idata     = ins;
    s_daddr     = a;
    s_rs2data   = d;
    step();
    s_req_valid = 1'b0;
  endtask
  initial begin
    logic [2:0] f3;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    send(SB, 32'h1003, 32'hAABBCCDD);
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hDD000000);
    step();
    chk("sb_done", done, 1);
    send(SH, 32'h2002, 32'h1234BEEF);
    chk("sh_addr", mem_addr, 32'h2000);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEF0000);
    step();
    send(SW, 32'h3001, 32'h11223344);
    chk("sw_b0_addr", mem_addr, 32'h3000);
    chk("sw_b0_wstrb", mem_wstrb, 4'b1110);
    chk("sw_b0_wdata", mem_wdata, 32'h22334400);
    step();
    chk("sw_b1_addr", mem_addr, 32'h3004);
    chk("sw_b1_wstrb", mem_wstrb, 4'b0001);
    chk("sw_b1_wdata", mem_wdata, 32'h00000011);
    chk("sw_b1_nodone", done, 0);
    step();
    chk("sw_done", done, 1);
    step();
    chk("sw_done_once", done, 0);
    send(3'b011, 32'h5000, 32'h1);
    chk("f3_err", err, 1);
    chk("f3_no_beat", mem_valid, 0);
    step();
    chk("f3_err_pulse", err, 0);
    mem_ready = 1'b0;
    send(SW, 32'h4000, 32'hCAFEF00D);
    repeat (3) begin
      chk("bp_addr", mem_addr, 32'h4000);
      chk("bp_wdata", mem_wdata, 32'hCAFEF00D);
      chk("bp_wstrb", mem_wstrb, 4'hF);
      chk("bp_ready", req_ready, 0);
      step();
    end
    mem_ready = 1'b1;
    step();
    chk("bp_done", done, 1);
    send(SW, 32'hFFFFFFFE, 32'hA1B2C3D4);
    chk("wrap_b0_addr", mem_addr, 32'hFFFFFFFC);
    chk("wrap_b0_wdata", mem_wdata, 32'hC3D40000);
    step();
    chk("wrap_b1_addr", mem_addr, 32'h00000000);
    chk("wrap_b1_wstrb", mem_wstrb, 4'b0011);
    chk("wrap_b1_wdata", mem_wdata, 32'h0000A1B2);
    step();
    s_send(st(SW), 32'h3001, 32'h11223344);
    chk("strict_mis_err", s_err, 1);
    chk("strict_mis_nobeat", s_mem_valid, 0);
    chk("strict_mis_ready", s_req_ready, 1);
    step();
    chk("strict_mis_quiet", s_mem_valid, 0);
    chk("strict_mis_pulse", s_err, 0);
    s_send(st(3'b011), 32'h3000, 32'h5);
    chk("strict_f3_err", s_err, 1);
    chk("strict_f3_nobeat", s_mem_valid, 0);
    step();
    s_send(st(SB), 32'h6001, 32'h55);
    chk("strict_sb_valid", s_mem_valid, 1);
    chk("strict_sb_addr", s_mem_addr, 32'h6000);
    chk("strict_sb_wstrb", s_mem_wstrb, 4'b0010);
    chk("strict_sb_wdata", s_mem_wdata, 32'h00005500);
    step();
    chk("strict_sb_done", s_done, 1);
    send(SW, 32'h3001, 32'h11223344);
    step();
    mem_ready = 1'b0;
    step();
    chk("mid_in_beat1", mem_wstrb, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_wstrb", mem_wstrb, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    step();
    chk("mid_no_done", done, 0);
    send(SB, 32'h7002, 32'h99);
    chk("post_addr", mem_addr, 32'h7000);
    chk("post_wstrb", mem_wstrb, 4'b0100);
    chk("post_wdata", mem_wdata, 32'h00990000);
    step();
    chk("post_done", done, 1);
    repeat (4000) begin
      f3 = ($urandom % 8 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      req_valid = $urandom % 4 != 0;
      idata = $urandom;
      idata[14:12] = f3;
      if ($urandom % 8 != 0) idata[6:0] = 7'b0100011;
      daddr = ($urandom % 8 == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      rs2data = $urandom;
      mem_ready = $urandom % 4 != 0;
      step();
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/s_type_store_unit.md
# s_type_store_unit

- Store-side counterpart to the load-data path: takes a RISC-V store instruction (SB/SH/SW), its byte address and rs2 data.
- Drives aligned word-write beats to data memory, with byte strobes and lane-shifted write data, over a valid/ready handshake.
- Misaligned stores that cross a word boundary are split into two aligned beats by a small FSM.
- Sits between the execute stage and the data-memory write port.

## Interface
Parameters:
- ALLOW_MISALIGNED, 1, 1 = split word-crossing stores into two beats; 0 = reject them with err.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request; equals (state == IDLE).
- idata  in  [MSB:LSB]  store instruction; opcode idata[6:0], funct3 idata[14:12].
- daddr  in  [MSB:LSB]  byte address (rs1 + imm).
- rs2data  in  [MSB:LSB]  data to store.
- mem_valid  out  1  write beat present.
- mem_ready  in  1  memory accepts beat.
- mem_addr  out  [MSB:LSB]  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  [MSB:LSB]  lane-positioned write data; unused lanes are 0.
- mem_wstrb  out  4  byte-lane enables.
- done  out  1  one-cycle pulse when the final beat of a store has been accepted.
- err  out  1  one-cycle pulse for a rejected request.

## Operation
- A request is accepted on req_valid && req_ready. All inputs are sampled on that edge.
- Validity:
  - Opcode must be 0100011 and funct3 must be one of SB=000, SH=001, SW=010.
  - Any other opcode or funct3 is rejected: err pulses, no memory traffic, unit stays IDLE.
- Beat calculation:
  - off = daddr[1:0]; size n = 1, 2 or 4 bytes.
  - mask8 = ((1<<n)-1) << off; data64 = {32'b0, rs2data[8n-1:0]} << (8*off).
  - Beat0: addr = {daddr[31:2], 2'b00}, wstrb = mask8[3:0], wdata = data64[31:0].
  - Beat1 exists only if mask8[7:4] != 0: addr = beat0 addr + 4 (mod 2^32), wstrb = mask8[7:4], wdata = data64[63:32].
- If beat1 would be needed and ALLOW_MISALIGNED=0: reject with err, no beats issued.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE -> BEAT0 on a valid accept.
  - BEAT0 -> IDLE on handshake if no beat1, otherwise BEAT0 -> BEAT1.
  - BEAT1 -> IDLE on handshake.
- mem_addr, mem_wdata, mem_wstrb and mem_valid are registered. They stay stable while mem_valid && !mem_ready.

## Timing
- Reset values: state IDLE, req_ready 1, mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, done 0, err 0.
- Accept at edge T: mem_valid is high from T+1.
- Beat handshake at edge H:
  - If more beats remain, the next beat is presented from H+1.
  - After the final beat, mem_valid falls, done = 1 and req_ready = 1 during H+1.
- A new request may be accepted in the done cycle. Sustained rate with mem_ready tied high:
  - Aligned stores: one every 2 cycles.
  - Split stores: one every 3 cycles.
- Rejected request accepted at T: err = 1 during T+1. req_ready stays 1, so back-to-back requests are allowed.
- mem_ready is ignored when mem_valid = 0.
- Address 0xFFFFFFFC-region split stores: beat1 address wraps to 0x00000000.
- rst_n low mid-store: outputs return to reset values immediately (asynchronously). Remaining beats are discarded and done is not raised.

## Structure
- The parameters package holds MSB/LSB, opcode constant STORE_OP = 7'b0100011, and funct3 constants SB/SH/SW alongside the existing LB/LH/LW/LBU/LHU.
- The package also holds the state enum typedef (IDLE, BEAT0, BEAT1).
- One natural combinational sub-module: store_lane_align. It takes funct3, off and rs2data, and produces mask8, data64 and a need_beat1 flag.

## Test plan
- SB, daddr=0x1003, rs2data=0xAABBCCDD, mem_ready=1 -> one beat: addr 0x1000, wstrb 1000, wdata 0xDD000000; done at T+2.
- SH, daddr=0x2002, rs2data=0x1234BEEF -> one beat: addr 0x2000, wstrb 1100, wdata 0xBEEF0000.
- SW, daddr=0x3001, rs2data=0x11223344, ALLOW_MISALIGNED=1 -> beat0 addr 0x3000, wstrb 1110, wdata 0x22334400; then beat1 addr 0x3004, wstrb 0001, wdata 0x00000011; single done pulse.
- Same SW with ALLOW_MISALIGNED=0, and separately funct3=011 -> err at T+1, mem_valid never rises.
- Backpressure: SW aligned, mem_ready low for 3 cycles -> outputs constant and req_ready 0 throughout. SW at daddr=0xFFFFFFFE -> beat1 addr 0x00000000.
- rst_n pulsed low while in BEAT1 -> mem_valid 0 immediately, no done; the next request completes normally.
